// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
// Shared constants and helpers for the priority encoder display block.
//   SEG_BLANK : active-low segment pattern with every segment off
//   seg_hex() : 4-bit value to active-low 7-segment pattern, bit 6 = seg g,
//               bit 0 = seg a
// -----------------------------------------------------------------------------
package prio_enc_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_hex(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/prio_enc_disp_seg7_hex_dec.sv
// -----------------------------------------------------------------------------
// seg7_hex_dec
// One hex digit decoder for an active-low 7-segment display.
// Ports:
//   nib  in  4  hex value to show
//   seg  out 7  active-low segments, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module seg7_hex_dec
  import prio_enc_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg_hex(nib);

endmodule

// File: rtl/prio_enc_disp.sv
// -----------------------------------------------------------------------------
// prio_enc_disp
// Registered priority encoder with a stability filter and a hex 7-segment
// readout of the committed index.
//
// Parameters:
//   N_IN        number of request inputs (>= 2)
//   STABLE_CYC  cycles a candidate must hold before it is committed (>= 1)
//   IDX_W, N_DIG are derived and must not be overridden
// Ports:
//   clk   in   1          system clock, rising edge
//   rst   in   1          asynchronous, active-high reset
//   x     in   N_IN       request vector, bit i = request i
//   en    in   1          encoder enable
//   hold  in   1          freeze committed outputs and restart the window
//   y     out  IDX_W      committed index of the highest set request
//   l     out  1          committed any-request flag
//   upd   out  1          one-cycle pulse when y or l changes
//   seg   out  7*N_DIG    active-low segments, digit d = seg[7d+6:7d]
// Build option:
//   PRIO_SEG_BLANK_EN  when defined, all digits are blanked while l = 0
// -----------------------------------------------------------------------------
module prio_enc_disp
  import prio_enc_pkg::*;
#(
  parameter  int N_IN       = 16,
  parameter  int STABLE_CYC = 4,
  localparam int IDX_W      = $clog2(N_IN),
  localparam int N_DIG      = (IDX_W + 3) / 4
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN-1:0]    x,
  input  logic               en,
  input  logic               hold,
  output logic [IDX_W-1:0]   y,
  output logic               l,
  output logic               upd,
  output logic [7*N_DIG-1:0] seg
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
  localparam int Y_EXT_W = 4 * N_DIG;

  logic [N_IN-1:0]  x_q, x_d;
  logic [IDX_W:0]   pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             l_q, l_d;
  logic             upd_q, upd_d;

  logic             c_any;
  logic [IDX_W-1:0] c_idx;
  logic [IDX_W:0]   cand;

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    c_any = |x_q;
    c_idx = '0;
    if (en && c_any) begin
      for (int i = 0; i < N_IN; i++) begin
        if (x_q[i]) c_idx = IDX_W'(i);
      end
    end
    cand = {c_any, c_idx};
  end

  always_comb begin
    x_d    = x;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    y_d    = y_q;
    l_d    = l_q;
    upd_d  = 1'b0;
    if (cand != pend_q) begin
      pend_d = cand;
      cnt_d  = '0;
    end else if (hold) begin
      // Holding also discards progress so release starts a fresh window.
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pend_q != {l_q, y_q}) begin
      {l_d, y_d} = pend_q;
      upd_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      l_q    <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      l_q    <= l_d;
      upd_q  <= upd_d;
    end
  end

  assign y   = y_q;
  assign l   = l_q;
  assign upd = upd_q;

  // Zero-extend y so the top digit reads unused high bits as 0.
  logic [Y_EXT_W-1:0] y_ext;
  assign y_ext = Y_EXT_W'(y_q);

  for (genvar d = 0; d < N_DIG; d++) begin : g_dig
    logic [6:0] dig_seg;

    seg7_hex_dec u_dec (
      .nib (y_ext[4*d +: 4]),
      .seg (dig_seg)
    );

`ifdef PRIO_SEG_BLANK_EN
    assign seg[7*d +: 7] = l_q ? dig_seg : SEG_BLANK;
`else
    assign seg[7*d +: 7] = dig_seg;
`endif
  end

endmodule

// File: tb/tb_prio_enc_disp.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_disp
// Directed bench for prio_enc_disp with N_IN = 16, STABLE_CYC = 4.
// -----------------------------------------------------------------------------
module tb_prio_enc_disp;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic        en;
  logic        hold;
  logic [3:0]  y;
  logic        l;
  logic        upd;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_F = 7'b0001110;

`ifdef PRIO_SEG_BLANK_EN
  localparam logic [6:0] SEG_IDLE = 7'b1111111;
`else
  localparam logic [6:0] SEG_IDLE = SEG_0;
`endif

  prio_enc_disp #(.N_IN(16), .STABLE_CYC(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .en   (en),
    .hold (hold),
    .y    (y),
    .l    (l),
    .upd  (upd),
    .seg  (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick();
      if (upd) p++;
    end
  endtask

  initial begin
    // 1: reset with all requests active
    rst = 1'b1; x = 16'hFFFF; en = 1'b1; hold = 1'b0;
    #1;
    chk("rst_y_async", 32'(y), 32'd0);
    tick(); tick();
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_l", 32'(l), 32'd0);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_seg", 32'(seg), 32'(SEG_IDLE));

    // 2: steady 0x0090 commits index 7 on edge 6
    rst = 1'b0; x = 16'h0090;
    run(5, pulses);
    chk("t2_early_y", 32'(y), 32'd0);
    chk("t2_early_upd", 32'(pulses), 32'd0);
    tick();
    chk("t2_y", 32'(y), 32'd7);
    chk("t2_l", 32'(l), 32'd1);
    chk("t2_upd", 32'(upd), 32'd1);
    chk("t2_seg", 32'(seg), 32'(SEG_7));
    run(10, pulses);
    chk("t2_stay_y", 32'(y), 32'd7);
    chk("t2_no_upd", 32'(pulses), 32'd0);

    // 3: three-cycle glitch to bit 15 is filtered out
    x = 16'h8000;
    run(3, pulses);
    x = 16'h0090;
    begin
      int p2;
      run(12, p2);
      pulses += p2;
    end
    chk("t3_y", 32'(y), 32'd7);
    chk("t3_no_upd", 32'(pulses), 32'd0);

    // 4: hold freezes output, release needs a fresh window
    x = 16'hC000; hold = 1'b1;
    run(20, pulses);
    chk("t4_hold_y", 32'(y), 32'd7);
    chk("t4_hold_upd", 32'(pulses), 32'd0);
    hold = 1'b0;
    run(3, pulses);
    chk("t4_rel3_y", 32'(y), 32'd7);
    chk("t4_rel3_upd", 32'(pulses), 32'd0);
    tick();
    chk("t4_y", 32'(y), 32'd15);
    chk("t4_upd", 32'(upd), 32'd1);
    chk("t4_seg", 32'(seg), 32'(SEG_F));

    // 5: disabled encoder reports index 0 but any-request set
    en = 1'b0; x = 16'h0F00;
    run(8, pulses);
    chk("t5_dis_y", 32'(y), 32'd0);
    chk("t5_dis_l", 32'(l), 32'd1);
    chk("t5_dis_seg", 32'(seg), 32'(SEG_0));
    chk("t5_dis_upd", 32'(pulses), 32'd1);
    en = 1'b1;
    run(4, pulses);
    chk("t5_en_early_y", 32'(y), 32'd0);
    begin
      int p2;
      run(2, p2);
      pulses += p2;
    end
    chk("t5_en_y", 32'(y), 32'd11);
    chk("t5_en_seg", 32'(seg), 32'(SEG_B));
    chk("t5_en_upd", 32'(pulses), 32'd1);
    x = 16'h0000;
    run(8, pulses);
    chk("t5_zero_y", 32'(y), 32'd0);
    chk("t5_zero_l", 32'(l), 32'd0);
    chk("t5_zero_upd", 32'(pulses), 32'd1);

    // 6: reset mid-count clears everything immediately
    x = 16'h0090;
    run(8, pulses);
    chk("t6_pre_y", 32'(y), 32'd7);
    x = 16'h4000;
    run(4, pulses);
    chk("t6_mid_y", 32'(y), 32'd7);
    #2;
    x = 16'h2000; rst = 1'b1;
    #1;
    chk("t6_async_y", 32'(y), 32'd0);
    chk("t6_async_l", 32'(l), 32'd0);
    chk("t6_async_upd", 32'(upd), 32'd0);
    chk("t6_async_seg", 32'(seg), 32'(SEG_IDLE));
    tick();
    rst = 1'b0;
    run(5, pulses);
    chk("t6_win_y", 32'(y), 32'd0);
    chk("t6_win_upd", 32'(pulses), 32'd0);
    tick();
    chk("t6_y", 32'(y), 32'd13);
    chk("t6_l", 32'(l), 32'd1);
    chk("t6_upd", 32'(upd), 32'd1);
    chk("t6_seg", 32'(seg), 32'(SEG_D));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
